// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial BCD add/subtract datapath.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for bcd_serial_addsub.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
) ();
    localparam int DW = 4 * DIGITS;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          m;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          carry;
    logic          neg;
    logic          err;

    modport master (
        output in_valid, a, b, m, out_ready,
        input  in_ready, out_valid, result, carry, neg, err
    );

    modport slave (
        input  in_valid, a, b, m, out_ready,
        output in_ready, out_valid, result, carry, neg, err
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// Single-digit BCD add/subtract cell: nines-complements b when m=1, then decimal-corrects.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   m,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   cout
);
    logic [BCD_DIGIT_W-1:0] b_eff;
    logic [BCD_DIGIT_W:0]   raw;

    // Binary digit sum followed by the +6 decimal adjust
    always_comb begin
        b_eff = m ? nines_comp(b) : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
        if (raw > 5'd9) begin
            s    = raw[BCD_DIGIT_W-1:0] + 4'd6;
            cout = 1'b1;
        end else begin
            s    = raw[BCD_DIGIT_W-1:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract engine, LSD first, one digit pair per clock.
// Define BCD_SIGN_MAG_EN to convert negative differences to sign-magnitude.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_serial_addsub_if.slave  bus
);
    localparam int              DW   = BCD_DIGIT_W * DIGITS;
    localparam int              CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, result_q, result_d;
    logic          m_q, m_d, cy_q, cy_d;
    logic          carry_q, carry_d, neg_q, neg_d, err_q, err_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [BCD_DIGIT_W-1:0] cell_a_s, cell_b_s, cell_s_s;
    logic                   cell_m_s, cell_cout_s;
    logic [DW+3:0]          res_cat_s;

    function automatic logic has_bad_nibble(input logic [DW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX);
        end
        return bad;
    endfunction

    bcd_digit_cell u_cell (
        .a    (cell_a_s),
        .b    (cell_b_s),
        .m    (cell_m_s),
        .cin  (cy_q),
        .s    (cell_s_s),
        .cout (cell_cout_s)
    );

    // FIX computes 0 - result through the same cell, walking the result register
    always_comb begin
        if (state_q == FIX) begin
            cell_a_s = 4'd0;
            cell_b_s = result_q[BCD_DIGIT_W-1:0];
            cell_m_s = 1'b1;
        end else begin
            cell_a_s = a_sh_q[BCD_DIGIT_W-1:0];
            cell_b_s = b_sh_q[BCD_DIGIT_W-1:0];
            cell_m_s = m_q;
        end
        res_cat_s = {cell_s_s, result_q};
    end

    // Next-state and next-output logic for the control FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        result_d    = result_q;
        m_d         = m_q;
        cy_d        = cy_q;
        carry_d     = carry_q;
        neg_d       = neg_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = RUN;
                    a_sh_d     = bus.a;
                    b_sh_d     = bus.b;
                    m_d        = bus.m;
                    cy_d       = bus.m;
                    cnt_d      = '0;
                    err_d      = has_bad_nibble(bus.a) | has_bad_nibble(bus.b);
                    carry_d    = 1'b0;
                    neg_d      = 1'b0;
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            RUN: begin
                result_d = res_cat_s[DW+3:BCD_DIGIT_W];
                a_sh_d   = a_sh_q >> BCD_DIGIT_W;
                b_sh_d   = b_sh_q >> BCD_DIGIT_W;
                cy_d     = cell_cout_s;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    carry_d = cell_cout_s;
                    neg_d   = m_q & ~cell_cout_s;
`ifdef BCD_SIGN_MAG_EN
                    if (m_q && !cell_cout_s) begin
                        state_d = FIX;
                        cy_d    = 1'b1;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
`else
                    state_d     = DONE;
                    out_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            FIX: begin
                result_d = res_cat_s[DW+3:BCD_DIGIT_W];
                cy_d     = cell_cout_s;
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            result_q    <= '0;
            m_q         <= 1'b0;
            cy_q        <= 1'b0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            result_q    <= result_d;
            m_q         <= m_d;
            cy_q        <= cy_d;
            carry_q     <= carry_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed cases plus random operations against a decimal-arithmetic model.
module tb_bcd_serial_addsub;
    localparam int DIGITS = 4;
    localparam int DW     = 4 * DIGITS;
    localparam int POW    = 10000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [DW-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [DW-1:0] int2bcd(input int v);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_bcd();
        logic [DW-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Reference: plain decimal arithmetic on the operand values
    task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m,
                         output logic [DW-1:0] res, output logic c, output logic n,
                         output logic e, output int lat);
        int ia, ib, s;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) e = e | (a[i*4 +: 4] > 4'd9) | (b[i*4 +: 4] > 4'd9);
        ia  = bcd2int(a);
        ib  = bcd2int(b);
        lat = DIGITS + 1;
        if (!m) begin
            s = ia + ib;  res = int2bcd(s % POW);  c = (s >= POW);  n = 1'b0;
        end else if (ia >= ib) begin
            res = int2bcd(ia - ib);  c = 1'b1;  n = 1'b0;
        end else begin
            c = 1'b0;  n = 1'b1;
`ifdef BCD_SIGN_MAG_EN
            res = int2bcd(ib - ia);
            lat = 2 * DIGITS + 1;
`else
            res = int2bcd(POW + ia - ib);
`endif
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m,
                          input int hold, input bit pulse);
        logic [DW-1:0] er;
        logic ec, en, ee;
        int el, w, lat;
        model(a, b, m, er, ec, en, ee, el);
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        check("in_ready_idle", bus.in_ready, 1'b1);
        bus.a = a;  bus.b = b;  bus.m = m;  bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("in_ready_busy", bus.in_ready, 1'b0);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        check("latency", lat, el);
        check("out_valid", bus.out_valid, 1'b1);
        check("err", bus.err, ee);
        if (!ee) begin
            check("result", bus.result, er);
            check("carry", bus.carry, ec);
            check("neg", bus.neg, en);
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                bus.in_valid = ~bus.in_valid;
                bus.a = rand_bcd();  bus.b = rand_bcd();  bus.m = ~bus.m;
            end
            @(posedge clk); #1;
            if (pulse) begin
                check("hold_result", bus.result, er);
                check("hold_in_ready", bus.in_ready, 1'b0);
                check("hold_valid", bus.out_valid, 1'b1);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 1'b0);
        check("in_ready_back", bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
        bus.a = '0;  bus.b = '0;  bus.m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 16'h0000);
        check("rst_carry", bus.carry, 1'b0);
        check("rst_neg", bus.neg, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 1'b0, 0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1, 0, 1'b0);
        run_op(16'h1234, 16'h5000, 1'b1, 2, 1'b0);
        run_op(16'h00A0, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h4321, 16'h8765, 1'b0, 10, 1'b1);

        // Reset in the middle of RUN discards the operation
        bus.a = 16'h2222;  bus.b = 16'h3333;  bus.m = 1'b0;  bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_result", bus.result, 16'h0000);
        check("mid_rst_carry", bus.carry, 1'b0);
        check("mid_rst_neg", bus.neg, 1'b0);
        check("mid_rst_err", bus.err, 1'b0);
        run_op(16'h0458, 16'h0999, 1'b1, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
